// File: rtl/tetris_pkg.sv
// tetris_pkg: shared move/state encodings and board geometry for the piece scheduler
package tetris_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2, DOWN = 2'd3} move_dir_t;
  typedef enum logic [2:0] {S_INIT, S_SPAWN, S_IDLE, S_MOVE, S_LOCK, S_OVER} sched_state_t;
  localparam int ROWS = 20;
  localparam int COLS = 10;
endpackage

// File: rtl/move_req_arbiter.sv
// move_req_arbiter: pending move latches with down-first, round-robin left/right select
module move_req_arbiter
  import tetris_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr_all,
  input  logic       set_left,
  input  logic       set_right,
  input  logic       set_down,
  input  logic       serve,
  input  logic [1:0] serve_dir,
  output logic       grant,
  output logic [1:0] dir
);
  logic pend_left, pend_right, pend_down, rr;
  logic eff_l, eff_r, eff_d;
  // Incoming pulses count immediately so a request in S_IDLE issues on the next cycle
  always_comb begin
    eff_l = pend_left | (en & set_left);
    eff_r = pend_right | (en & set_right);
    eff_d = pend_down | (en & set_down);
    grant = eff_l | eff_r | eff_d;
    dir = eff_d ? DOWN : (eff_l & eff_r) ? (rr ? RIGHT : LEFT) : eff_l ? LEFT : eff_r ? RIGHT : NONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {pend_left, pend_right, pend_down, rr} <= '0;
    end else if (clr_all) begin
      {pend_left, pend_right, pend_down} <= '0;
    end else begin
      pend_left <= (pend_left & ~(serve & (serve_dir == LEFT))) | (en & set_left);
      pend_right <= (pend_right & ~(serve & (serve_dir == RIGHT))) | (en & set_right);
      pend_down <= (pend_down & ~(serve & (serve_dir == DOWN))) | (en & set_down);
      if (serve && (serve_dir == LEFT || serve_dir == RIGHT)) rr <= ~rr;
    end
endmodule

// File: rtl/tetris_move_scheduler.sv
// tetris_move_scheduler: issues one piece move at a time, then locks and spawns on landing
module tetris_move_scheduler
  import tetris_pkg::*;
#(
  parameter int LOCK_DELAY = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_down,
  input  logic             gravity_tick,
  output logic             mv_valid,
  output logic [1:0]       mv_dir,
  input  logic             mv_done,
  input  logic             mv_moved,
  output logic             lock_req,
  input  logic             lock_done,
  output logic             spawn_req,
  input  logic             spawn_done,
  input  logic             spawn_ok,
  output logic             busy,
  output logic             game_over,
  output logic [CNT_W-1:0] pieces_placed
);
  localparam int GW = $clog2(LOCK_DELAY + 1);
  sched_state_t state, nxt;
  logic [GW-1:0] gcnt, gnext;
  logic [1:0] dir_q, arb_dir;
  logic armed, grant, done_ok, lock_hit, latch_en, can_start;
  assign latch_en = state == S_IDLE || state == S_MOVE;
  assign can_start = (state == S_INIT || state == S_OVER) && start;
  // mv_done is honoured only once mv_valid has been up for a full cycle
  assign done_ok = state == S_MOVE && armed && mv_done;
  assign gnext = gcnt + GW'(1);
  assign lock_hit = dir_q == DOWN && !mv_moved && gnext == GW'(LOCK_DELAY);
  assign mv_valid = state == S_MOVE;
  assign mv_dir = mv_valid ? dir_q : NONE;
  assign lock_req = state == S_LOCK;
  assign spawn_req = state == S_SPAWN;
  assign busy = state == S_SPAWN || state == S_MOVE || state == S_LOCK;
  move_req_arbiter u_arb (
    .clk(clk),
    .reset(reset),
    .en(latch_en),
    .clr_all(done_ok && lock_hit),
    .set_left(btn_left),
    .set_right(btn_right),
    .set_down(btn_down | gravity_tick),
    .serve(done_ok),
    .serve_dir(dir_q),
    .grant(grant),
    .dir(arb_dir)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_INIT;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_INIT, S_OVER: nxt = start ? S_SPAWN : state;
      S_SPAWN: nxt = spawn_done ? (spawn_ok ? S_IDLE : S_OVER) : S_SPAWN;
      S_IDLE: nxt = grant ? S_MOVE : S_IDLE;
      S_MOVE: nxt = done_ok ? (lock_hit ? S_LOCK : S_IDLE) : S_MOVE;
      S_LOCK: nxt = lock_done ? S_SPAWN : S_LOCK;
      default: nxt = S_INIT;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gcnt <= '0;
      dir_q <= NONE;
      armed <= 1'b0;
      game_over <= 1'b0;
      pieces_placed <= '0;
    end else begin
      armed <= state == S_MOVE;
      if (state == S_IDLE && grant) dir_q <= arb_dir;
      if (done_ok && dir_q == DOWN) gcnt <= mv_moved ? '0 : gnext;
      if (state == S_SPAWN && spawn_done && !spawn_ok) game_over <= 1'b1;
      if (state == S_LOCK && lock_done) begin
        pieces_placed <= pieces_placed + CNT_W'(1);
        gcnt <= '0;
      end
      if (can_start) begin
        pieces_placed <= '0;
        gcnt <= '0;
        game_over <= 1'b0;
      end
    end
endmodule

// File: tb/tb_tetris_move_scheduler.sv
// tb_tetris_move_scheduler: directed stimulus with a request scoreboard popped on output rises
module tb_tetris_move_scheduler;
  logic clk = 0, reset = 1;
  logic start = 0, btn_left = 0, btn_right = 0, btn_down = 0, gravity_tick = 0;
  logic mv_done = 0, mv_moved = 0, lock_done = 0, spawn_done = 0, spawn_ok = 0;
  logic mv_valid, lock_req, spawn_req, busy, game_over;
  logic [1:0] mv_dir;
  logic [15:0] pieces_placed;
  int checks = 0, failures = 0;
  int exp_q[$];
  logic pv_mv = 0, pv_lock = 0, pv_spawn = 0;

  tetris_move_scheduler #(.LOCK_DELAY(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .btn_left(btn_left), .btn_right(btn_right),
    .btn_down(btn_down), .gravity_tick(gravity_tick), .mv_valid(mv_valid), .mv_dir(mv_dir),
    .mv_done(mv_done), .mv_moved(mv_moved), .lock_req(lock_req), .lock_done(lock_done),
    .spawn_req(spawn_req), .spawn_done(spawn_done), .spawn_ok(spawn_ok), .busy(busy),
    .game_over(game_over), .pieces_placed(pieces_placed)
  );

  always #5 clk = ~clk;

  // Expected request codes: 10+dir for a move, 20 for lock, 30 for spawn
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input string name, input int act);
    if (exp_q.size() == 0) check({name, "_unexpected"}, act, 0);
    else check(name, act, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (mv_valid && !pv_mv) pop_cmp("mv_req", 10 + int'(mv_dir));
    if (lock_req && !pv_lock) pop_cmp("lock_req_evt", 20);
    if (spawn_req && !pv_spawn) pop_cmp("spawn_req_evt", 30);
    pv_mv <= mv_valid;
    pv_lock <= lock_req;
    pv_spawn <= spawn_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mv();
    int n = 0;
    while (!mv_valid && n < 8) begin
      step();
      n++;
    end
    if (!mv_valid) check("wait_mv_timeout", 0, 1);
  endtask

  task automatic do_move(input int d, input bit moved, input bit g);
    check("mv_valid", int'(mv_valid), 1);
    check("mv_dir", int'(mv_dir), d);
    step();
    check("mv_hold", mv_valid ? int'(mv_dir) : 9, d);
    mv_done = 1;
    mv_moved = moved;
    gravity_tick = g;
    step();
    mv_done = 0;
    mv_moved = 0;
    gravity_tick = 0;
  endtask

  task automatic spawn_ack(input bit ok);
    spawn_done = 1;
    spawn_ok = ok;
    step();
    spawn_done = 0;
    spawn_ok = 0;
  endtask

  task automatic gravity();
    gravity_tick = 1;
    step();
    gravity_tick = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    step();
    step();
    check("rst_mv_valid", int'(mv_valid), 0);
    check("rst_mv_dir", int'(mv_dir), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_pieces", int'(pieces_placed), 0);
    check("rst_spawn_req", int'(spawn_req), 0);
    reset = 0;
    step();
    exp_q.push_back(30);
    start = 1;
    step();
    start = 0;
    check("spawn_req_on", int'(spawn_req), 1);
    check("spawn_busy", int'(busy), 1);
    spawn_ack(1);
    check("spawn_req_off", int'(spawn_req), 0);
    check("idle_busy", int'(busy), 0);
    mv_done = 1;
    lock_done = 1;
    step();
    mv_done = 0;
    lock_done = 0;
    check("stray_done_busy", int'(busy), 0);
    start = 1;
    step();
    start = 0;
    check("start_ignored", int'(spawn_req), 0);
    exp_q.push_back(11);
    exp_q.push_back(12);
    btn_left = 1;
    btn_right = 1;
    step();
    btn_left = 0;
    btn_right = 0;
    do_move(1, 1, 0);
    check("between_lr", int'(mv_valid), 0);
    wait_mv();
    do_move(2, 1, 0);
    exp_q.push_back(11);
    exp_q.push_back(13);
    btn_left = 1;
    step();
    btn_left = 0;
    check("left_valid", int'(mv_dir), 1);
    gravity_tick = 1;
    step();
    gravity_tick = 0;
    check("left_hold", int'(mv_dir), 1);
    btn_down = 1;
    mv_done = 1;
    mv_moved = 0;
    step();
    btn_down = 0;
    mv_done = 0;
    wait_mv();
    do_move(3, 1, 0);
    step();
    step();
    step();
    check("one_down_only", int'(mv_valid), 0);
    exp_q.push_back(13);
    gravity();
    do_move(3, 0, 0);
    check("grounded1_idle", int'(busy), 0);
    exp_q.push_back(13);
    exp_q.push_back(20);
    gravity();
    do_move(3, 0, 0);
    check("lock_req_on", int'(lock_req), 1);
    check("lock_pieces0", int'(pieces_placed), 0);
    btn_left = 1;
    step();
    btn_left = 0;
    exp_q.push_back(30);
    lock_done = 1;
    step();
    lock_done = 0;
    check("pieces_1", int'(pieces_placed), 1);
    check("lock_spawn", int'(spawn_req), 1);
    check("lock_req_off", int'(lock_req), 0);
    spawn_ack(1);
    step();
    check("lock_drop_btn", int'(mv_valid), 0);
    exp_q.push_back(13);
    exp_q.push_back(13);
    gravity();
    do_move(3, 0, 1);
    wait_mv();
    do_move(3, 1, 0);
    exp_q.push_back(13);
    gravity();
    do_move(3, 0, 0);
    check("no_lock_req", int'(lock_req), 0);
    check("no_lock_busy", int'(busy), 0);
    check("no_lock_pieces", int'(pieces_placed), 1);
    exp_q.push_back(13);
    exp_q.push_back(20);
    gravity();
    do_move(3, 0, 0);
    check("lock2_req", int'(lock_req), 1);
    exp_q.push_back(30);
    lock_done = 1;
    step();
    lock_done = 0;
    check("pieces_2", int'(pieces_placed), 2);
    spawn_ack(0);
    check("game_over_set", int'(game_over), 1);
    check("over_busy", int'(busy), 0);
    check("over_pieces", int'(pieces_placed), 2);
    btn_left = 1;
    btn_down = 1;
    gravity_tick = 1;
    spawn_done = 1;
    step();
    btn_left = 0;
    btn_down = 0;
    gravity_tick = 0;
    spawn_done = 0;
    step();
    check("over_btn", int'(mv_valid), 0);
    check("over_sticky", int'(game_over), 1);
    exp_q.push_back(30);
    start = 1;
    step();
    start = 0;
    check("restart_game_over", int'(game_over), 0);
    check("restart_pieces", int'(pieces_placed), 0);
    check("restart_spawn", int'(spawn_req), 1);
    spawn_ack(1);
    exp_q.push_back(12);
    btn_right = 1;
    step();
    btn_right = 0;
    check("right_valid", int'(mv_valid), 1);
    @(negedge clk);
    #1;
    reset = 1;
    #1;
    check("arst_mv_valid", int'(mv_valid), 0);
    check("arst_mv_dir", int'(mv_dir), 0);
    check("arst_busy", int'(busy), 0);
    step();
    reset = 0;
    btn_left = 1;
    step();
    btn_left = 0;
    step();
    check("init_ignores_btn", int'(mv_valid), 0);
    check("init_no_spawn", int'(spawn_req), 0);
    exp_q.push_back(30);
    start = 1;
    step();
    start = 0;
    check("init_start_spawn", int'(spawn_req), 1);
    spawn_ack(1);
    step();
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
